sparse_dot_accum: RTL and testbench

- Downstream consumer of the index-compare stage in the sparse matrix multiplier.
- Each cycle the compare stage presents an equal-index flag and a 6-bit partial product. This block sums the products of matching index pairs over one row/column pass, delimited by a last flag.
- Presents the finished dot product, plus a match count, through a valid/ready handshake to the result writer.

---
 rtl/sparse_pkg.sv | 14 +
 rtl/sparse_acc_adder.sv | 30 +++
 rtl/sparse_dot_accum.sv | 145 ++++++++++++++
 tb/tb_sparse_dot_accum.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_pkg.sv
// Shared types and default widths for the sparse dot-product accumulator.
package sparse_pkg;

  // ACCUM: collecting beats of a pass; HOLD: finished result awaiting handshake
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  localparam int PROD_W_DEF = 6;
  localparam int ACC_W_DEF  = 16;
  localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/sparse_acc_adder.sv
// Accumulator adder with carry detection.
// Build option: SPARSE_ACC_SAT_EN selects a clamping adder (result pinned at
// all-ones on carry); otherwise the sum wraps modulo 2^ACC_W. The carry flag is
// reported in both builds so the caller can keep a sticky overflow bit.
module sparse_acc_adder #(
  parameter int PROD_W = 6,
  parameter int ACC_W  = 16
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] addend_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  // One extra bit catches the carry out of the accumulator width.
  logic [ACC_W:0] wide_sum;

  assign wide_sum = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, addend_i};
  assign carry_o  = wide_sum[ACC_W];

`ifdef SPARSE_ACC_SAT_EN
  // Clamp on carry; once at all-ones any nonzero addend carries again, so the
  // value stays pinned for the rest of the pass.
  assign sum_o = carry_o ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
`else
  // Plain modulo-2^ACC_W wrap.
  assign sum_o = wide_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/sparse_dot_accum.sv
// Sparse dot-product accumulator: sums partial products of matching index
// pairs over one pass (terminated by in_last) and hands the result, a match
// count and a sticky overflow flag to the result writer via valid/ready.
// Build option: SPARSE_ACC_SAT_EN (saturating accumulator, handled inside
// sparse_acc_adder; the control path here is the same in both builds).
module sparse_dot_accum
  import sparse_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              eq,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  sum_out,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              overflow
);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             overflow_q, overflow_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic             beat_acc;

  // Running totals including the current beat, used both to keep
  // accumulating and to load the result on the last beat.
  logic [ACC_W-1:0] acc_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic             ovf_upd;

  sparse_acc_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .acc_i    (acc_q),
    .addend_i (prod_in),
    .sum_o    (add_sum),
    .carry_o  (add_carry)
  );

  // Ready depends on state only, never on in_valid.
  assign in_ready = (state_q == ACCUM);
  assign beat_acc = in_valid & in_ready;

  // Fold in this beat's contribution when the indices matched.
  always_comb begin
    acc_upd = acc_q;
    cnt_upd = cnt_q;
    ovf_upd = ovf_q;
    if (eq) begin
      acc_upd = add_sum;
      ovf_upd = ovf_q | add_carry;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_upd = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Next-state and register-update logic for the ACCUM/HOLD controller.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    match_cnt_d = match_cnt_q;
    overflow_d  = overflow_q;
    unique case (state_q)
      ACCUM: begin
        if (beat_acc) begin
          if (in_last) begin
            // Publish the finished pass and start the next one from zero.
            sum_d       = acc_upd;
            match_cnt_d = cnt_upd;
            overflow_d  = ovf_upd;
            out_valid_d = 1'b1;
            state_d     = HOLD;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
          end else begin
            acc_d = acc_upd;
            cnt_d = cnt_upd;
            ovf_d = ovf_upd;
          end
        end
      end
      HOLD: begin
        // Result registers keep their values after the handshake.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      match_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      match_cnt_q <= match_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum_out   = sum_q;
  assign match_cnt = match_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sparse_dot_accum.sv
// Bench for sparse_dot_accum: a 16-bit and an 8-bit accumulator instance share
// the same input stream; a pass-level reference model predicts each result.
module tb_sparse_dot_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        eq;
  logic [5:0]  prod_in;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid, overflow;
  logic [15:0] sum_out;
  logic [7:0]  match_cnt;
  logic        in_ready8, out_valid8, overflow8;
  logic [7:0]  sum_out8;
  logic [7:0]  match_cnt8;

  int errors = 0;
  int checks = 0;
  int handshakes = 0;

  typedef struct {
    int s16; int o16; int s8; int o8; int c;
  } exp_t;
  exp_t exp_q[$];

  int tot = 0;
  int mcnt = 0;

  always #5 clk = ~clk;

  sparse_dot_accum u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .eq(eq), .prod_in(prod_in), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .sum_out(sum_out), .match_cnt(match_cnt),
    .overflow(overflow)
  );

  sparse_dot_accum #(.ACC_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
    .eq(eq), .prod_in(prod_in), .in_last(in_last), .out_valid(out_valid8),
    .out_ready(out_ready), .sum_out(sum_out8), .match_cnt(match_cnt8),
    .overflow(overflow8)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Expected result of a pass whose true (unbounded) sum is t, at width w.
  function automatic int exp_sum(input int t, input int w);
    int mx;
    mx = (1 << w) - 1;
`ifdef SPARSE_ACC_SAT_EN
    return (t > mx) ? mx : t;
`else
    return t % (1 << w);
`endif
  endfunction

  // Reference model: record an accepted beat at pass level.
  task automatic model_accept(input logic e, input int p, input logic l);
    exp_t x;
    if (e) begin
      tot += p;
      mcnt++;
    end
    if (l) begin
      x.s16 = exp_sum(tot, 16);
      x.o16 = (tot > 65535) ? 1 : 0;
      x.s8  = exp_sum(tot, 8);
      x.o8  = (tot > 255) ? 1 : 0;
      x.c   = (mcnt > 255) ? 255 : mcnt;
      exp_q.push_back(x);
      tot  = 0;
      mcnt = 0;
    end
  endtask

  task automatic model_reset();
    tot  = 0;
    mcnt = 0;
    exp_q.delete();
  endtask

  // Scoreboard: every completed output handshake is compared with the model.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      exp_t x;
      handshakes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        x = exp_q.pop_front();
        chk("sum16", int'(sum_out), x.s16);
        chk("ovf16", int'(overflow), x.o16);
        chk("cnt16", int'(match_cnt), x.c);
        chk("valid8", int'(out_valid8), 1);
        chk("sum8", int'(sum_out8), x.s8);
        chk("ovf8", int'(overflow8), x.o8);
        chk("cnt8", int'(match_cnt8), x.c);
        $display("result: sum16=%0d sum8=%0d cnt=%0d ovf16=%0d ovf8=%0d",
                 sum_out, sum_out8, match_cnt, overflow, overflow8);
      end
    end
  end

  task automatic send_beat(input logic e, input int p, input logic l,
                           input bit hold_valid);
    int n;
    n = 0;
    in_valid = 1'b1;
    eq       = e;
    prod_in  = p[5:0];
    in_last  = l;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", int'(in_ready), 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    model_accept(e, p, l);
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int target;
    bit have_beat, accepted;
    logic re, rl;
    int rp, n;

    reset = 1'b1; in_valid = 1'b0; eq = 1'b0; prod_in = '0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sum", int'(sum_out), 0);
    chk("rst_cnt", int'(match_cnt), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("post_rst_in_ready", int'(in_ready), 1);

    // Basic pass, out_ready high: result one cycle after last, ready low one cycle
    send_beat(1, 35, 0, 0);
    send_beat(0, 63, 0, 0);
    send_beat(1, 5, 0, 0);
    send_beat(1, 10, 1, 0);
    chk("basic_valid", int'(out_valid), 1);
    chk("basic_sum", int'(sum_out), 50);
    chk("basic_cnt", int'(match_cnt), 3);
    chk("basic_ovf", int'(overflow), 0);
    chk("basic_ready_low", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("basic_valid_drop", int'(out_valid), 0);
    chk("basic_ready_back", int'(in_ready), 1);

    // Backpressure: result held stable for 5 cycles
    out_ready = 1'b0;
    send_beat(1, 35, 0, 0);
    send_beat(0, 63, 0, 0);
    send_beat(1, 5, 0, 0);
    send_beat(1, 10, 1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_sum", int'(sum_out), 50);
      chk("bp_ready", int'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_drop", int'(out_valid), 0);
    chk("bp_ready_back", int'(in_ready), 1);
    chk("bp_sum_kept", int'(sum_out), 50);

    // Empty match pass
    send_beat(0, 63, 1, 0);
    chk("empty_valid", int'(out_valid), 1);
    chk("empty_sum", int'(sum_out), 0);
    chk("empty_cnt", int'(match_cnt), 0);
    @(posedge clk); #1;

    // Overflow: six beats of 63 (378)
    for (int i = 0; i < 6; i++) send_beat(1, 63, (i == 5), 0);
`ifdef SPARSE_ACC_SAT_EN
    chk("ovf_sum8", int'(sum_out8), 255);
`else
    chk("ovf_sum8", int'(sum_out8), 122);
`endif
    chk("ovf_flag8", int'(overflow8), 1);
    chk("ovf_sum16", int'(sum_out), 378);
    chk("ovf_flag16", int'(overflow), 0);
    @(posedge clk); #1;

    // Match counter saturation: 300 matching beats of 1
    for (int i = 0; i < 300; i++) send_beat(1, 1, (i == 299), 1);
    in_valid = 1'b0;
    chk("sat_cnt", int'(match_cnt), 255);
    chk("sat_sum16", int'(sum_out), 300);
    @(posedge clk); #1;

    // Reset mid-pass: partial sum discarded
    send_beat(1, 20, 0, 0);
    send_beat(1, 20, 0, 0);
    do_reset();
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_ready", int'(in_ready), 1);
    send_beat(1, 7, 1, 0);
    chk("midrst_sum", int'(sum_out), 7);
    chk("midrst_cnt", int'(match_cnt), 1);
    @(posedge clk); #1;

    // Reset during HOLD: pending result dropped
    out_ready = 1'b0;
    send_beat(1, 9, 1, 0);
    chk("holdrst_pre_valid", int'(out_valid), 1);
    do_reset();
    chk("holdrst_valid", int'(out_valid), 0);
    chk("holdrst_sum", int'(sum_out), 0);
    out_ready = 1'b1;

    // Back-to-back passes with in_valid held high
    n = handshakes;
    send_beat(1, 5, 0, 1);
    send_beat(1, 7, 1, 1);
    chk("b2b_a_sum", int'(sum_out), 12);
    send_beat(1, 10, 0, 1);
    send_beat(1, 20, 1, 0);
    chk("b2b_b_sum", int'(sum_out), 30);
    @(posedge clk); #1;
    chk("b2b_handshakes", handshakes - n, 2);

    // Randomized traffic with random backpressure and idle cycles
    have_beat = 0; re = 0; rp = 0; rl = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!have_beat) begin
        re = ($urandom_range(0, 3) != 0);
        rp = $urandom_range(0, 63);
        target = $urandom_range(0, 7);
        rl = (target == 0);
        have_beat = 1;
      end
      in_valid = ($urandom_range(0, 4) != 0);
      eq = re; prod_in = rp[5:0]; in_last = rl;
      accepted = in_valid && in_ready;
      @(posedge clk); #1;
      if (accepted) begin
        model_accept(re, rp, rl);
        have_beat = 0;
      end
    end

    // Close any open pass, then drain
    if (tot != 0 || mcnt != 0 || have_beat) send_beat(0, 0, 1, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("final_ready", int'(in_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
